// File: rtl/game_download_rx_pkg.sv
// ---------------------------------------------------------------------------
// game_dl_pkg
// Shared constants and types for the game download receiver: start-of-frame
// byte, loader file type codes, error code enum and the FSM state types.
// Optional feature macro: GAME_DOWNLOAD_CHECKSUM_EN adds the CSUM state.
// ---------------------------------------------------------------------------
package game_dl_pkg;

  localparam logic [7:0] SOF_BYTE      = 8'hA5;
  localparam logic [7:0] FILETYPE_BIOS = 8'h0A;
  localparam logic [7:0] FILETYPE_FDS  = 8'h0B;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_FRAME   = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_CSUM    = 2'd3
  } errCode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TYPE = 3'd1,
    ST_LEN0 = 3'd2,
    ST_LEN1 = 3'd3,
    ST_LEN2 = 3'd4,
    ST_DATA = 3'd5,
`ifdef GAME_DOWNLOAD_CHECKSUM_EN
    ST_CSUM = 3'd6,
`endif
    ST_ERR  = 3'd7
  } dlState_e;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_DONE  = 3'd4
  } rxState_e;

  function automatic logic isSof(input logic [7:0] b);
    return b == SOF_BYTE;
  endfunction

endpackage

// File: rtl/game_download_rx_if.sv
// ---------------------------------------------------------------------------
// game_download_rx_if
// Bundles the serial input and the loader/status outputs of the download
// receiver.
//   uart_rx     serial line, idle high, 8N1 LSB first
//   downloading high while payload bytes are being delivered
//   filetype    packet type byte
//   indata      payload byte, valid with indata_clk
//   indata_clk  one-cycle payload strobe
//   error       sticky error flag
//   err_code    error cause (errCode_e)
//   bytes_rcvd  payload bytes forwarded in current/last packet
// Modports: master = host/serial side, slave = receiver side.
// ---------------------------------------------------------------------------
interface game_download_rx_if;
  import game_dl_pkg::*;

  logic        uart_rx;
  logic        downloading;
  logic [7:0]  filetype;
  logic [7:0]  indata;
  logic        indata_clk;
  logic        error;
  errCode_e    err_code;
  logic [23:0] bytes_rcvd;

  modport master (
    output uart_rx,
    input  downloading, filetype, indata, indata_clk, error, err_code, bytes_rcvd
  );

  modport slave (
    input  uart_rx,
    output downloading, filetype, indata, indata_clk, error, err_code, bytes_rcvd
  );

endinterface

// File: rtl/game_download_rx_uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// 8N1 UART receiver with a 2-FF synchroniser and mid-bit sampling.
//   clk, reset   system clock, synchronous active-high reset
//   rx_i         asynchronous serial input (idle high)
//   rx_data_o    received byte, valid while rx_valid_o is high
//   rx_valid_o   one-cycle pulse, the clock after a good stop bit sample
//   rx_ferr_o    one-cycle pulse, the clock after a low stop bit sample
// Parameter CLKS_PER_BIT must be at least 8.
// ---------------------------------------------------------------------------
module uart_rx_core
  import game_dl_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_ferr_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync1_q, sync2_q, prev_q;
  rxState_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic             stopBit_q, stopBit_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             fallEdge;

  // Edge-triggered start so a line held low after a bad stop bit does not
  // immediately re-trigger a new frame.
  assign fallEdge = prev_q & ~sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      stopBit_q <= 1'b1;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync1_q   <= rx_i;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      stopBit_q <= stopBit_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    stopBit_d = stopBit_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      RX_IDLE: begin
        if (fallEdge) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      // A start bit that is high again at half a bit time was a glitch.
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d    = '0;
          bitIdx_d = '0;
          state_d  = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bitIdx_q == 3'd7) state_d = RX_STOP;
          else                  bitIdx_d = bitIdx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          stopBit_d = sync2_q;
          state_d   = RX_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Report the frame one clock after the stop sample; a new start edge
      // arriving in this cycle is still honoured.
      RX_DONE: begin
        valid_d = stopBit_q;
        ferr_d  = ~stopBit_q;
        cnt_d   = '0;
        state_d = fallEdge ? RX_START : RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_data_o  = shift_q;
  assign rx_valid_o = valid_q;
  assign rx_ferr_o  = ferr_q;

endmodule

// File: rtl/game_download_rx.sv
// ---------------------------------------------------------------------------
// game_download_rx
// UART front end for game download. Parses
//   0xA5, TYPE, LEN[7:0], LEN[15:8], LEN[23:16], LEN payload bytes [, CSUM]
// and forwards each payload byte to the loader as a single strobe.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   bus         game_download_rx_if.slave (serial in, loader/status outputs)
// Parameters: CLK_HZ, BAUD (CLK_HZ/BAUD must be >= 8), TIMEOUT_CYCLES.
// Optional feature macro: GAME_DOWNLOAD_CHECKSUM_EN -- XOR checksum trailer
// after the payload, mismatch reported as err_code 3.
// ---------------------------------------------------------------------------
module game_download_rx
  import game_dl_pkg::*;
#(
  parameter int CLK_HZ         = 21477272,
  parameter int BAUD           = 115200,
  parameter int TIMEOUT_CYCLES = 2147727
) (
  input logic               clk,
  input logic               reset,
  game_download_rx_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [7:0] rxData;
  logic       rxValid, rxFerr;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx_i      (bus.uart_rx),
    .rx_data_o (rxData),
    .rx_valid_o(rxValid),
    .rx_ferr_o (rxFerr)
  );

  dlState_e    state_q, state_d;
  logic [7:0]  filetype_q, filetype_d;
  logic [7:0]  indata_q, indata_d;
  logic        indataClk_q, indataClk_d;
  logic        downloading_q, downloading_d;
  logic        error_q, error_d;
  errCode_e    errCode_q, errCode_d;
  logic [23:0] bytesRcvd_q, bytesRcvd_d;
  logic [15:0] len_q, len_d;
  logic [23:0] lenRem_q, lenRem_d;
  logic [TO_W-1:0] toCnt_q, toCnt_d;
`ifdef GAME_DOWNLOAD_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic [23:0] lenFull;
  logic        inPacket;
  logic        timeoutHit;

  assign lenFull    = {rxData, len_q};
  assign inPacket   = (state_q != ST_IDLE) && (state_q != ST_ERR);
  assign timeoutHit = inPacket && !rxValid && (toCnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      filetype_q    <= '0;
      indata_q      <= '0;
      indataClk_q   <= 1'b0;
      downloading_q <= 1'b0;
      error_q       <= 1'b0;
      errCode_q     <= ERR_NONE;
      bytesRcvd_q   <= '0;
      len_q         <= '0;
      lenRem_q      <= '0;
      toCnt_q       <= '0;
`ifdef GAME_DOWNLOAD_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      filetype_q    <= filetype_d;
      indata_q      <= indata_d;
      indataClk_q   <= indataClk_d;
      downloading_q <= downloading_d;
      error_q       <= error_d;
      errCode_q     <= errCode_d;
      bytesRcvd_q   <= bytesRcvd_d;
      len_q         <= len_d;
      lenRem_q      <= lenRem_d;
      toCnt_q       <= toCnt_d;
`ifdef GAME_DOWNLOAD_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    filetype_d    = filetype_q;
    indata_d      = indata_q;
    indataClk_d   = 1'b0;
    downloading_d = downloading_q;
    error_d       = error_q;
    errCode_d     = errCode_q;
    bytesRcvd_d   = bytesRcvd_q;
    len_d         = len_q;
    lenRem_d      = lenRem_q;
`ifdef GAME_DOWNLOAD_CHECKSUM_EN
    csum_d        = csum_q;
`endif
    // The inter-byte timer only runs inside a packet.
    toCnt_d = (rxValid || !inPacket) ? '0 : toCnt_q + 1'b1;

    case (state_q)
      // Outside a packet only a SOF matters; downloading drops here, which
      // puts the falling edge one clock after the final strobe.
      ST_IDLE, ST_ERR: begin
        downloading_d = 1'b0;
        if (rxValid && isSof(rxData)) begin
          state_d     = ST_TYPE;
          error_d     = 1'b0;
          errCode_d   = ERR_NONE;
          bytesRcvd_d = '0;
        end
      end
      default: begin
        if (rxFerr) begin
          state_d       = ST_ERR;
          downloading_d = 1'b0;
          error_d       = 1'b1;
          errCode_d     = ERR_FRAME;
        end else if (timeoutHit) begin
          state_d       = ST_ERR;
          downloading_d = 1'b0;
          error_d       = 1'b1;
          errCode_d     = ERR_TIMEOUT;
        end else if (rxValid) begin
          case (state_q)
            ST_TYPE: begin
              filetype_d = rxData;
              state_d    = ST_LEN0;
            end
            ST_LEN0: begin
              len_d[7:0] = rxData;
              state_d    = ST_LEN1;
            end
            ST_LEN1: begin
              len_d[15:8] = rxData;
              state_d     = ST_LEN2;
            end
            ST_LEN2: begin
              if (lenFull == '0) begin
                state_d = ST_IDLE;
              end else begin
                state_d       = ST_DATA;
                downloading_d = 1'b1;
                lenRem_d      = lenFull;
`ifdef GAME_DOWNLOAD_CHECKSUM_EN
                csum_d        = '0;
`endif
              end
            end
            // SOF bytes here are payload; no resync inside a packet.
            ST_DATA: begin
              indata_d    = rxData;
              indataClk_d = 1'b1;
              bytesRcvd_d = bytesRcvd_q + 24'd1;
              lenRem_d    = lenRem_q - 24'd1;
`ifdef GAME_DOWNLOAD_CHECKSUM_EN
              csum_d      = csum_q ^ rxData;
              if (lenRem_q == 24'd1) state_d = ST_CSUM;
`else
              if (lenRem_q == 24'd1) state_d = ST_IDLE;
`endif
            end
`ifdef GAME_DOWNLOAD_CHECKSUM_EN
            // Forwarded data is not retracted on a bad checksum.
            ST_CSUM: begin
              if (rxData == csum_q) begin
                state_d = ST_IDLE;
              end else begin
                state_d       = ST_ERR;
                downloading_d = 1'b0;
                error_d       = 1'b1;
                errCode_d     = ERR_CSUM;
              end
            end
`endif
            default: state_d = state_q;
          endcase
        end
      end
    endcase
  end

  assign bus.downloading = downloading_q;
  assign bus.filetype    = filetype_q;
  assign bus.indata      = indata_q;
  assign bus.indata_clk  = indataClk_q;
  assign bus.error       = error_q;
  assign bus.err_code    = errCode_q;
  assign bus.bytes_rcvd  = bytesRcvd_q;

endmodule

// File: tb/tb_game_download_rx.sv
// ---------------------------------------------------------------------------
// tb_game_download_rx
// Bench for game_download_rx at 10 clocks per bit and a 500-clock timeout.
// Serial frames are driven bit by bit; payload bytes expected at the loader
// are queued as they are sent and matched against the strobes captured by
// a monitor.
// ---------------------------------------------------------------------------
module tb_game_download_rx;
  import game_dl_pkg::*;

  localparam int CPB = 10;

  typedef struct {
    logic [7:0]  ftype;
    logic [23:0] len;
    logic [31:0] pay;
    logic [7:0]  expFt;
    logic [23:0] expBytes;
    logic        expNoDl;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  game_download_rx_if bus();

  game_download_rx #(
    .CLK_HZ        (1152000),
    .BAUD          (115200),
    .TIMEOUT_CYCLES(500)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: captures loader bytes and downloading behaviour.
  logic [7:0] gotQ[$];
  logic [7:0] expQ[$];
  int   lastStrobeCyc = 0;
  int   dlCycles      = 0;
  int   dlLowOnStrobe = 0;
  logic prevStrobe    = 1'b0;
  logic dlAfterStrobe = 1'b0;

  always @(negedge clk) begin
    if (bus.indata_clk) begin
      gotQ.push_back(bus.indata);
      lastStrobeCyc <= cyc;
      if (!bus.downloading) dlLowOnStrobe <= dlLowOnStrobe + 1;
    end
    if (bus.downloading) dlCycles <= dlCycles + 1;
    if (prevStrobe) dlAfterStrobe <= bus.downloading;
    prevStrobe <= bus.indata_clk;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got no finish, expected finish within 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    logic [9:0] frame;
    frame = {stopBit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.uart_rx = frame[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    bus.uart_rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic sendHeader(input logic [7:0] ftype, input logic [23:0] len);
    sendByte(SOF_BYTE, 1'b1);
    sendByte(ftype, 1'b1);
    sendByte(len[7:0], 1'b1);
    sendByte(len[15:8], 1'b1);
    sendByte(len[23:16], 1'b1);
  endtask

  task automatic sendPayload(input logic [7:0] b);
    expQ.push_back(b);
    sendByte(b, 1'b1);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [7:0] b;
    logic [7:0] csum;
    csum = 8'h00;
    sendHeader(v.ftype, v.len);
    for (int i = 0; i < int'(v.len); i++) begin
      b = v.pay[8*i +: 8];
      csum = csum ^ b;
      sendPayload(b);
    end
`ifdef GAME_DOWNLOAD_CHECKSUM_EN
    if (v.len != 24'd0) sendByte(csum, 1'b1);
`endif
  endtask

  task automatic drainScoreboard(input string name);
    logic [7:0] e;
    logic [7:0] g;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (gotQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL %s_indata: got no strobe, expected 0x%0h", name, e);
      end else begin
        g = gotQ.pop_front();
        checkOutput({name, "_indata"}, 32'(g), 32'(e));
      end
    end
    checkOutput({name, "_extra_strobes"}, gotQ.size(), 0);
    gotQ.delete();
  endtask

  initial begin
    vec_t vecs[4];
    int   dlBefore;

    vecs[0] = '{8'h00,         24'd4, 32'h44332211, 8'h00, 24'd4, 1'b0};
    vecs[1] = '{FILETYPE_FDS,  24'd2, 32'h0000A5A5, 8'h0B, 24'd2, 1'b0};
    vecs[2] = '{8'h00,         24'd0, 32'h00000000, 8'h00, 24'd0, 1'b1};
    vecs[3] = '{FILETYPE_BIOS, 24'd3, 32'h00030201, 8'h0A, 24'd3, 1'b0};

    reset       = 1'b1;
    bus.uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_downloading", bus.downloading, 0);
    checkOutput("rst_filetype", bus.filetype, 0);
    checkOutput("rst_indata", bus.indata, 0);
    checkOutput("rst_indata_clk", bus.indata_clk, 0);
    checkOutput("rst_error", bus.error, 0);
    checkOutput("rst_err_code", bus.err_code, 0);
    checkOutput("rst_bytes_rcvd", bus.bytes_rcvd, 0);

    // Table-driven packets: normal, SOF inside payload, empty, BIOS type.
    for (int k = 0; k < 4; k++) begin
      dlBefore = dlCycles;
      applyStimulus(vecs[k]);
      repeat (20) @(negedge clk);
      checkOutput($sformatf("v%0d_filetype", k), bus.filetype, vecs[k].expFt);
      checkOutput($sformatf("v%0d_bytes_rcvd", k), bus.bytes_rcvd, vecs[k].expBytes);
      checkOutput($sformatf("v%0d_error", k), bus.error, 0);
      checkOutput($sformatf("v%0d_err_code", k), bus.err_code, ERR_NONE);
      checkOutput($sformatf("v%0d_downloading_end", k), bus.downloading, 0);
      checkOutput($sformatf("v%0d_no_dl", k), 32'((dlCycles - dlBefore) == 0),
                  32'(vecs[k].expNoDl));
      if (vecs[k].len != 24'd0) begin
`ifdef GAME_DOWNLOAD_CHECKSUM_EN
        checkOutput($sformatf("v%0d_dl_after_last", k), dlAfterStrobe, 1);
`else
        checkOutput($sformatf("v%0d_dl_after_last", k), dlAfterStrobe, 0);
`endif
      end
      drainScoreboard($sformatf("v%0d", k));
    end
    checkOutput("dl_low_on_strobe", dlLowOnStrobe, 0);

    // Framing error on the second payload byte, then recovery via SOF.
    sendHeader(8'h00, 24'd3);
    sendPayload(8'h11);
    sendByte(8'h22, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("ferr_error", bus.error, 1);
    checkOutput("ferr_err_code", bus.err_code, ERR_FRAME);
    checkOutput("ferr_downloading", bus.downloading, 0);
    drainScoreboard("ferr");
    sendHeader(FILETYPE_BIOS, 24'd1);
    sendPayload(8'h7E);
`ifdef GAME_DOWNLOAD_CHECKSUM_EN
    sendByte(8'h7E, 1'b1);
`endif
    repeat (20) @(negedge clk);
    checkOutput("recov_error", bus.error, 0);
    checkOutput("recov_err_code", bus.err_code, ERR_NONE);
    checkOutput("recov_filetype", bus.filetype, 8'h0A);
    checkOutput("recov_bytes_rcvd", bus.bytes_rcvd, 1);
    drainScoreboard("recov");

    // One-clock low glitch between payload bytes must not create a byte.
    sendHeader(8'h00, 24'd2);
    sendPayload(8'h33);
    repeat (5) @(negedge clk);
    bus.uart_rx = 1'b0;
    @(negedge clk);
    bus.uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    sendPayload(8'h44);
`ifdef GAME_DOWNLOAD_CHECKSUM_EN
    sendByte(8'h77, 1'b1);
`endif
    repeat (20) @(negedge clk);
    checkOutput("glitch_bytes_rcvd", bus.bytes_rcvd, 2);
    checkOutput("glitch_error", bus.error, 0);
    drainScoreboard("glitch");

    // Silence after one of three payload bytes: timeout ~500 clocks later.
    sendHeader(8'h00, 24'd3);
    sendPayload(8'h01);
    while (cyc < lastStrobeCyc + 490) @(negedge clk);
    checkOutput("to_early_error", bus.error, 0);
    while (cyc < lastStrobeCyc + 510) @(negedge clk);
    checkOutput("to_error", bus.error, 1);
    checkOutput("to_err_code", bus.err_code, ERR_TIMEOUT);
    checkOutput("to_downloading", bus.downloading, 0);
    drainScoreboard("to");

    // Reset in the middle of a payload clears everything on the next clock.
    sendHeader(FILETYPE_FDS, 24'd4);
    sendPayload(8'h11);
    sendPayload(8'h22);
    checkOutput("rstmid_dl_before", bus.downloading, 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_downloading", bus.downloading, 0);
    checkOutput("rstmid_filetype", bus.filetype, 0);
    checkOutput("rstmid_indata", bus.indata, 0);
    checkOutput("rstmid_bytes_rcvd", bus.bytes_rcvd, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    drainScoreboard("rstmid");

`ifdef GAME_DOWNLOAD_CHECKSUM_EN
    sendHeader(8'h00, 24'd2);
    sendPayload(8'h0F);
    sendPayload(8'hF0);
    sendByte(8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("csum_ok_error", bus.error, 0);
    checkOutput("csum_ok_downloading", bus.downloading, 0);
    drainScoreboard("csum_ok");
    sendHeader(8'h00, 24'd2);
    sendPayload(8'h0F);
    sendPayload(8'hF0);
    sendByte(8'h00, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("csum_bad_error", bus.error, 1);
    checkOutput("csum_bad_err_code", bus.err_code, ERR_CSUM);
    drainScoreboard("csum_bad");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
